rect_fill: RTL and testbench

- Parametrised successor to the full-screen fill engine.
- Plots every pixel of a caller-specified rectangle, clipped to a configurable screen size, one pixel per clock.
- Offers four colour modes: solid, column stripes, row stripes, checkerboard.
- Sits between the top-level control (switches/keys or a higher-level sequencer) and the VGA adapter's x/y/colour/plot inputs, and uses the start/done handshake.

---
 rtl/rect_fill.sv | 163 ++++++++++++++++
 tb/tb_rect_fill.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rect_fill.sv
// Rectangle fill engine: plots a screen-clipped rectangle one pixel per clock,
// column-major, into a VGA adapter's x/y/colour/plot port.
module rect_fill #(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120,
    parameter int XW       = 8,
    parameter int YW       = 7,
    parameter int CW       = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [XW-1:0] x0,
    input  logic [YW-1:0] y0,
    input  logic [XW-1:0] width,
    input  logic [YW-1:0] height,
    input  logic [CW-1:0] colour,
    input  logic [1:0]    mode,
    output logic          busy,
    output logic          done,
    output logic [XW-1:0] vga_x,
    output logic [YW-1:0] vga_y,
    output logic [CW-1:0] vga_colour,
    output logic          vga_plot,
    output logic [1:0]    dbg_state
);

    // Handshake: the requester raises start and holds it until done is seen;
    // done stays high while start is held and drops the cycle after start falls.
    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_FILL, S_DONE} state_t;

    localparam logic [XW:0] SW = (XW+1)'(SCREEN_W);
    localparam logic [YW:0] SH = (YW+1)'(SCREEN_H);

    state_t        state_q, state_d;
    logic [XW-1:0] x0_q, w_q, xe_q, xe_d, x_q, x_d;
    logic [YW-1:0] y0_q, h_q, ye_q, ye_d, y_q, y_d;
    logic [CW-1:0] col_q, colour_q, colour_d;
    logic [1:0]    mode_q;
    logic          plot_q, plot_d, busy_q, busy_d, done_q, done_d, latch_en;

    logic [XW:0] x_sum, x_end;
    logic [YW:0] y_sum, y_end;
    logic        empty;

    // Sums are one bit wider so oversize rectangles clip instead of wrapping.
    assign x_sum = {1'b0, x0_q} + {1'b0, w_q};
    assign y_sum = {1'b0, y0_q} + {1'b0, h_q};
    assign x_end = ((x_sum > SW) ? SW : x_sum) - (XW+1)'(1);
    assign y_end = ((y_sum > SH) ? SH : y_sum) - (YW+1)'(1);
    assign empty = (w_q == '0) || (h_q == '0) ||
                   ({1'b0, x0_q} >= SW) || ({1'b0, y0_q} >= SH);

    function automatic logic [CW-1:0] pix_colour(input logic [XW-1:0] px,
                                                 input logic [YW-1:0] py,
                                                 input logic [1:0]    pm,
                                                 input logic [CW-1:0] pc);
        logic [CW-1:0] c;
        case (pm)
            2'b00:   c = pc;
            2'b01:   c = px[CW-1:0];
            2'b10:   c = py[CW-1:0];
            default: c = (px[3] ^ py[3]) ? ~pc : pc;
        endcase
        return c;
    endfunction

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        xe_d     = xe_q;
        ye_d     = ye_q;
        plot_d   = 1'b0;
        latch_en = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_SETUP;
                    latch_en = 1'b1;
                end
            end
            S_SETUP: begin
                xe_d = x_end[XW-1:0];
                ye_d = y_end[YW-1:0];
                x_d  = x0_q;
                y_d  = y0_q;
                if (empty) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_FILL;
                    plot_d  = 1'b1;
                end
            end
            S_FILL: begin
                if (x_q == xe_q && y_q == ye_q) begin
                    state_d = S_DONE;
                end else begin
                    plot_d = 1'b1;
                    if (y_q == ye_q) begin
                        y_d = y0_q;
                        x_d = x_q + XW'(1);
                    end else begin
                        y_d = y_q + YW'(1);
                    end
                end
            end
            default: begin
                if (!start) state_d = S_IDLE;
            end
        endcase
        colour_d = pix_colour(x_d, y_d, mode_q, col_q);
        busy_d   = (state_d == S_SETUP) || (state_d == S_FILL);
        done_d   = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            x0_q     <= '0;
            y0_q     <= '0;
            w_q      <= '0;
            h_q      <= '0;
            col_q    <= '0;
            mode_q   <= '0;
            xe_q     <= '0;
            ye_q     <= '0;
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
            plot_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            xe_q     <= xe_d;
            ye_q     <= ye_d;
            x_q      <= x_d;
            y_q      <= y_d;
            colour_q <= colour_d;
            plot_q   <= plot_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            if (latch_en) begin
                x0_q   <= x0;
                y0_q   <= y0;
                w_q    <= width;
                h_q    <= height;
                col_q  <= colour;
                mode_q <= mode;
            end
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign vga_x      = x_q;
    assign vga_y      = y_q;
    assign vga_colour = colour_q;
    assign vga_plot   = plot_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_rect_fill.sv
// Directed bench for rect_fill: expected pixel queue checked by a plot monitor,
// plus handshake, clipping, empty-request and mid-fill reset checks.
module tb_rect_fill;

    localparam int XW = 8;
    localparam int YW = 7;
    localparam int CW = 3;
    localparam int PW = XW + YW + CW;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [XW-1:0] x0;
    logic [YW-1:0] y0;
    logic [XW-1:0] width;
    logic [YW-1:0] height;
    logic [CW-1:0] colour;
    logic [1:0]    mode;
    logic          busy, done, vga_plot;
    logic [XW-1:0] vga_x;
    logic [YW-1:0] vga_y;
    logic [CW-1:0] vga_colour;
    logic [1:0]    dbg_state;

    logic [PW-1:0] exp_q[$];
    int            n_checks = 0;
    int            n_fail   = 0;
    int            plot_cnt = 0;

    rect_fill dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .x0         (x0),
        .y0         (y0),
        .width      (width),
        .height     (height),
        .colour     (colour),
        .mode       (mode),
        .busy       (busy),
        .done       (done),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     tag, got, got, exp, exp, $time);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (rst_n && vga_plot) begin
            plot_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_plot", {vga_x, vga_y, vga_colour}, 32'hFFFF_FFFF);
            end else begin
                check("pixel", {vga_x, vga_y, vga_colour}, exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_pix(input int px, input int py, input int pc);
        logic [XW-1:0] xv;
        logic [YW-1:0] yv;
        logic [CW-1:0] cv;
        xv = XW'(px);
        yv = YW'(py);
        cv = CW'(pc);
        exp_q.push_back({xv, yv, cv});
    endtask

    // Raises start and returns at the negedge after the first FILL/DONE edge.
    task automatic start_req(input int rx, input int ry, input int rw, input int rh,
                             input int rc, input int rm);
        @(negedge clk);
        x0     = XW'(rx);
        y0     = YW'(ry);
        width  = XW'(rw);
        height = YW'(rh);
        colour = CW'(rc);
        mode   = 2'(rm);
        start  = 1'b1;
        plot_cnt = 0;
        @(posedge clk);
        @(negedge clk);
        check("setup_busy", busy, 1);
        check("setup_no_plot", vga_plot, 0);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("done_reached", done, 1);
    endtask

    task automatic drop_start;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("done_fall", done, 0);
        check("idle_busy", busy, 0);
    endtask

    task automatic check_end(input int ex, input int ey, input int ecnt);
        check("end_plot", vga_plot, 0);
        check("end_busy", busy, 0);
        check("end_x", vga_x, ex);
        check("end_y", vga_y, ey);
        check("plot_count", plot_cnt, ecnt);
        check("queue_empty", exp_q.size(), 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0; start = 1'b0;
        x0 = '0; y0 = '0; width = '0; height = '0; colour = '0; mode = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_plot", vga_plot, 0);
        check("rst_xyc", {vga_x, vga_y, vga_colour}, 0);
        check("rst_state", dbg_state, 0);
        rst_n = 1'b1;

        // Full screen, solid 101
        for (int x = 0; x < 160; x++)
            for (int y = 0; y < 120; y++)
                push_pix(x, y, 5);
        start_req(0, 0, 160, 120, 5, 0);
        check("fs_first_plot", vga_plot, 1);
        check("fs_first_xy", {vga_x, vga_y}, 0);
        wait_done(20000);
        check_end(159, 119, 19200);
        drop_start();

        // Column stripes (10,20,3,2)
        push_pix(10, 20, 2); push_pix(10, 21, 2);
        push_pix(11, 20, 3); push_pix(11, 21, 3);
        push_pix(12, 20, 4); push_pix(12, 21, 4);
        start_req(10, 20, 3, 2, 0, 1);
        check("cs_first_plot", vga_plot, 1);
        wait_done(50);
        check_end(12, 21, 6);

        // Handshake: done holds while start stays high
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("done_hold", done, 1);
            check("done_hold_plot", vga_plot, 0);
        end
        drop_start();

        // Single pixel follow-up request
        push_pix(0, 0, 5);
        start_req(0, 0, 1, 1, 5, 0);
        check("single_plot", vga_plot, 1);
        wait_done(10);
        check_end(0, 0, 1);
        drop_start();

        // Clipping at the bottom-right corner, row stripes
        push_pix(158, 118, 6); push_pix(158, 119, 7);
        push_pix(159, 118, 6); push_pix(159, 119, 7);
        start_req(158, 118, 5, 5, 1, 2);
        wait_done(50);
        check_end(159, 119, 4);
        drop_start();

        // Checkerboard across the x[3] boundary: x=7,8 at y=0 with colour 2
        push_pix(7, 0, 2); push_pix(8, 0, 5);
        start_req(7, 0, 2, 1, 2, 3);
        wait_done(20);
        check_end(8, 0, 2);
        drop_start();

        // Empty: zero width
        start_req(5, 5, 0, 4, 3, 0);
        check("empty_done", done, 1);
        check_end(5, 5, 0);
        drop_start();

        // Off-screen x0
        start_req(200, 10, 4, 4, 3, 0);
        check("offscreen_done", done, 1);
        check_end(200, 10, 0);
        drop_start();

        // Reset in the middle of a fill, then restart with start still high
        for (int x = 0; x < 20; x++)
            for (int y = 0; y < 10; y++)
                push_pix(x, y, 2);
        start_req(0, 0, 20, 10, 2, 0);
        begin
            int n;
            n = 0;
            while (plot_cnt < 50 && n < 400) begin
                @(negedge clk);
                n++;
            end
        end
        check("mid_fill_reached", (plot_cnt >= 50) ? 1 : 0, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_plot", vga_plot, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_xyc", {vga_x, vga_y, vga_colour}, 0);
        check("arst_state", dbg_state, 0);
        exp_q.delete();
        for (int x = 0; x < 20; x++)
            for (int y = 0; y < 10; y++)
                push_pix(x, y, 2);
        @(negedge clk);
        plot_cnt = 0;
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("restart_setup", busy, 1);
        @(posedge clk);
        @(negedge clk);
        check("restart_first", {vga_plot, vga_x, vga_y}, {1'b1, 8'd0, 7'd0});
        wait_done(400);
        check_end(19, 9, 200);
        drop_start();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
